// File: rtl/tick_arbiter_if.sv
// Requester-side bundle for tick_arbiter: run enable, request/done levels and grant status.
interface tick_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic             tick;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             busy;
    logic             timeout;

    modport master (
        output en, req, done,
        input  tick, grant, grant_id, busy, timeout
    );

    modport slave (
        input  en, req, done,
        output tick, grant, grant_id, busy, timeout
    );
endinterface

// File: rtl/tick_arbiter.sv
// Periodic round-robin slot scheduler: a prescaler tick opens a grant window, the grant is held
// until done, request withdrawal, or a tick-counted hold limit forces release.
module tick_arbiter #(
    parameter int unsigned TICK_DIV = 100,
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input logic           clk,
    input logic           rst_n,
    tick_arbiter_if.slave bus_io
);
    localparam int unsigned CNT_W  = $clog2(TICK_DIV);
    localparam int unsigned ID_W   = $clog2(N_REQ);
    localparam int unsigned SUM_W  = ID_W + 1;
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    localparam logic [CNT_W-1:0]  CntLast  = CNT_W'(TICK_DIV - 1);
    localparam logic [ID_W-1:0]   IdLast   = ID_W'(N_REQ - 1);
    localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(MAX_HOLD - 1);
    localparam logic [SUM_W-1:0]  NReqSum  = SUM_W'(N_REQ);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    logic               tick;
    logic               win_valid;
    logic [ID_W-1:0]    win_id;
    logic [SUM_W-1:0]   rr_sum;
    logic               rel_norm;
    logic               rel_force;
    logic [ID_W-1:0]    next_ptr;

    // Prescaler next count: wraps at TICK_DIV-1, held at zero while disabled.
    always_comb begin
        cnt_d = '0;
        if (bus_io.en) begin
            cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = bus_io.en && (cnt_q == CntLast);

    // Round-robin search: first asserted request starting at ptr and wrapping past N_REQ-1.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        rr_sum    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rr_sum = {1'b0, ptr_q} + SUM_W'(i);
            if (rr_sum >= NReqSum) begin
                rr_sum = rr_sum - NReqSum;
            end
            if (!win_valid && bus_io.req[ID_W'(rr_sum)]) begin
                win_valid = 1'b1;
                win_id    = ID_W'(rr_sum);
            end
        end
    end

    // Normal release always beats the forced one, so a late done never reports a timeout.
    assign rel_norm  = bus_io.done[grant_id_q] || !bus_io.req[grant_id_q];
    assign rel_force = tick && (hold_q == HoldLast);
    assign next_ptr  = (grant_id_q == IdLast) ? '0 : grant_id_q + 1'b1;

    // Next-state and registered-output logic of the grant FSM.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tick && win_valid) begin
                    state_d         = StGrant;
                    grant_d         = '0;
                    grant_d[win_id] = 1'b1;
                    grant_id_d      = win_id;
                    busy_d          = 1'b1;
                    hold_d          = '0;
                end
            end
            StGrant: begin
                if (rel_norm || rel_force) begin
                    // A release edge never grants; the next grant waits for a later tick.
                    state_d    = StIdle;
                    grant_d    = '0;
                    grant_id_d = '0;
                    busy_d     = 1'b0;
                    hold_d     = '0;
                    timeout_d  = !rel_norm;
                    ptr_d      = next_ptr;
                end else if (tick) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ptr_q      <= '0;
            hold_q     <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus_io.tick     = tick;
    assign bus_io.grant    = grant_q;
    assign bus_io.grant_id = grant_id_q;
    assign bus_io.busy     = busy_q;
    assign bus_io.timeout  = timeout_q;

endmodule
